// File: rtl/pito_imem_loader_pkg.sv
// Shared RV32 types for the pito instruction-memory subsystem: data word,
// default address type and the loader FSM state encoding.
package rv32_utils;

    localparam int unsigned RV32_XLEN = 32;
    typedef logic [RV32_XLEN-1:0] rv32_data_t;

    // Default instruction-memory geometry. Modules with a different DEPTH
    // derive their own address type locally from their ADDR_W.
    localparam int unsigned IMEM_DEPTH_DEFAULT  = 1024;
    localparam int unsigned IMEM_ADDR_W_DEFAULT = $clog2(IMEM_DEPTH_DEFAULT);
    typedef logic [IMEM_ADDR_W_DEFAULT-1:0] imem_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_ld_state_t;

endpackage

// File: rtl/pito_imem_loader_if.sv
// Bus bundle between the program source / fetch stage and the loader.
//
// Stream handshake: a word on ld_data is transferred on a rising clock edge
// exactly when ld_valid and ld_ready are both high at that edge. ld_ready is
// a pure function of loader state (never of ld_valid); the source may raise
// or drop ld_valid at any time and a beat without both high moves nothing.
//
// Read port: rd_en/rd_addr sampled on an edge produce rd_data with
// rd_valid = 1 in the following cycle; rd_data holds while rd_en is low.
interface pito_imem_loader_if
    import rv32_utils::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_len;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_wrapped;
    logic [DATA_W-1:0] ld_checksum;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    imem_ld_state_t    dbg_state;

    modport master (
        output ld_start, ld_base, ld_len, ld_data, ld_valid, rd_en, rd_addr,
        input  ld_ready, ld_busy, ld_done, ld_wrapped, ld_checksum,
               rd_data, rd_valid, dbg_state
    );

    modport slave (
        input  ld_start, ld_base, ld_len, ld_data, ld_valid, rd_en, rd_addr,
        output ld_ready, ld_busy, ld_done, ld_wrapped, ld_checksum,
               rd_data, rd_valid, dbg_state
    );

endinterface

// File: rtl/pito_dp_ram.sv
// Generic simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address on one edge returns the old word.
// The storage array has no reset; only the read output register does.
module pito_dp_ram #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage write; intentionally not reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; sampling before the write lands gives old data on collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pito_imem_loader.sv
// Instruction-memory subsystem: dual-port RAM filled by a streaming loader
// with auto-incrementing (wrapping) pointer, wrap flag and running checksum.
// DEPTH must be a power of two (>= 4) so the pointer wraps by overflow.
module pito_imem_loader
    import rv32_utils::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    pito_imem_loader_if.slave bus
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;

    imem_ld_state_t    r_state;
    imem_ld_state_t    w_state_nxt;
    addr_t             r_ptr;
    count_t            r_remaining;
    logic [DATA_W-1:0] r_checksum;
    logic              r_wrapped;
    logic              r_rd_valid;

    logic              w_start;
    logic              w_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_data;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; ready depends on state only
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ready     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.ld_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = (bus.ld_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (bus.ld_valid && (r_remaining == count_t'(1))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = w_ready & bus.ld_valid;

    // Write pointer and remaining-word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_ptr       <= bus.ld_base;
            r_remaining <= bus.ld_len;
        end else if (w_accept) begin
            r_ptr       <= r_ptr + addr_t'(1);
            r_remaining <= r_remaining - count_t'(1);
        end
    end

    // Checksum and sticky wrap flag; both held until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
            r_wrapped  <= 1'b0;
        end else if (w_start) begin
            r_checksum <= '0;
            r_wrapped  <= 1'b0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + bus.ld_data;
            // Only a wrap followed by at least one more beat counts
            if ((r_ptr == addr_t'(DEPTH - 1)) && (r_remaining > count_t'(1))) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    // Read-valid tracks the one-cycle latency of the RAM read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
        end
    end

    pito_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_ptr),
        .i_wr_data (bus.ld_data),
        .i_rd_en   (bus.rd_en),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign bus.ld_ready    = w_ready;
    assign bus.ld_busy     = w_busy;
    assign bus.ld_done     = w_done;
    assign bus.ld_wrapped  = r_wrapped;
    assign bus.ld_checksum = r_checksum;
    assign bus.rd_data     = w_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.dbg_state   = r_state;

endmodule
